// File: rtl/npu_cube_defs.sv
// Shared constants for the NPU cube adder tree.
// Default datapath widths and the carry-vector weight shift used by every
// ADD_LEVEL stage and by the final resolver.
package npu_cube_defs;

  // Default width of the redundant sum vector entering the resolver.
  localparam int DWIN_DEF  = 15;
  // Default accumulator / result width.
  localparam int DWACC_DEF = 21;
  // Carry bit i carries weight 2^(i+CAY_SHIFT) relative to the sum vector.
  localparam int CAY_SHIFT = 1;

endpackage

// File: rtl/npu_cube_csa_cpa.sv
// Purpose: resolve a carry-save sum/carry pair into one binary value.
// Latency: purely combinational, zero cycles.
// Backpressure: none; this block has no handshake.
module npu_cube_csa_cpa
  import npu_cube_defs::*;
#(
  parameter int W = DWIN_DEF
) (
  input  logic [W-1:0] i_sum,
  input  logic [W-2:0] i_cay,
  output logic [W:0]   o_res   // o_res[W] is the carry-out of the addition
);

  // One extra bit covers the worst case sum + 2*cay without truncation.
  assign o_res = (W+1)'(i_sum) + ((W+1)'(i_cay) << CAY_SHIFT);

endmodule

// File: rtl/npu_cube_csa_resolve_acc.sv
// Purpose: resolve the final CSA pair and accumulate it over the K-chunks of a group.
// Latency: a last beat accepted in cycle t presents its result in cycle t+2.
// Backpressure: only a last beat in s1 waits on a full output register; others flow.
module npu_cube_csa_resolve_acc
  import npu_cube_defs::*;
#(
  parameter int DWIN   = DWIN_DEF,
  parameter int DWACC  = DWACC_DEF,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DWIN-1:0]  in_sum,
  input  logic [DWIN-2:0]  in_cay,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DWACC-1:0] out_data,
  output logic             out_ovf,
  output logic             err_restart
);

  localparam int RW = DWIN + 1;   // resolved value width
  localparam int SW = DWACC + 1;  // accumulator sum width incl. overflow bit

  logic [RW-1:0]    w_res;
  logic             w_s2_ok;
  logic             w_s1_adv;
  logic [DWACC-1:0] w_base;
  logic [SW-1:0]    w_sum;
  logic             w_ovf;
  logic [DWACC-1:0] w_next;
  logic             w_grp_ovf_next;

  logic             r_live;
  logic             r_s1_valid;
  logic [RW-1:0]    r_s1_res;
  logic             r_s1_first;
  logic             r_s1_last;
  logic [DWACC-1:0] r_acc;
  logic             r_acc_open;
  logic             r_grp_ovf;
  logic             r_out_valid;
  logic [DWACC-1:0] r_out_data;
  logic             r_out_ovf;
  logic             r_err;

  npu_cube_csa_cpa #(.W(DWIN)) u_cpa (
    .i_sum (in_sum),
    .i_cay (in_cay),
    .o_res (w_res)
  );

  // A last beat may only leave s1 if the output register is free or draining now.
  assign w_s2_ok  = !(r_s1_last && r_out_valid && !out_ready);
  assign w_s1_adv = r_s1_valid && w_s2_ok;
  // r_live keeps in_ready low during reset and the cycle it is released.
  assign in_ready = r_live && (!r_s1_valid || w_s2_ok);

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_ovf     = r_out_ovf;
  assign err_restart = r_err;

  // Marks the block as out of reset so the input side can open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_live <= 1'b0;
    else     r_live <= 1'b1;
  end

  // Stage 1: capture the resolved value with its group markers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_res   <= '0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_res   <= w_res;
        r_s1_first <= in_first;
        r_s1_last  <= in_last;
      end
    end
  end

  // Stage 2 datapath: add onto the running sum (or onto zero for a new group).
  always_comb begin
    w_base         = r_s1_first ? '0 : r_acc;
    w_sum          = {1'b0, w_base} + SW'(r_s1_res);
    w_ovf          = w_sum[DWACC];
    w_next         = w_sum[DWACC-1:0];
    if (w_ovf && SAT_EN) w_next = '1;
    w_grp_ovf_next = (r_s1_first ? 1'b0 : r_grp_ovf) | w_ovf;
  end

  // Stage 2 state: accumulator, open-group tracking and the restart pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_acc_open <= 1'b0;
      r_grp_ovf  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_s1_adv && r_s1_first && r_acc_open;
      if (w_s1_adv) begin
        r_acc      <= w_next;
        r_grp_ovf  <= w_grp_ovf_next;
        r_acc_open <= !r_s1_last;
      end
    end
  end

  // Output register: load on a group's last beat, hold until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_s1_adv && r_s1_last) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_next;
      r_out_ovf   <= w_grp_ovf_next;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/npu_cube_csa_resolve_acc.md
Name: npu_cube_csa_resolve_acc

Overview:
- Receiving end of the NPU cube carry-save adder tree. Takes the final redundant sum/carry pair from the last compressor level, resolves it with a carry-propagate adder, and accumulates resolved values across K-chunks of one output element.
- Emits one binary result per accumulation group over a valid/ready handshake towards the cube output buffer.
- Sits between the final ADD_LEVEL stage and the output writeback.

Parameters:
- DWIN, 15, width of in_sum; in_cay is DWIN-1 bits, and carry bit i has weight 2^(i+1).
- DWACC, 21, accumulator and result width.
- SAT_EN, 1, 1 = saturate at 2^DWACC-1; 0 = wrap modulo 2^DWACC.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- in_sum  input  DWIN  redundant sum vector.
- in_cay  input  DWIN-1  redundant carry vector, pre-shift.
- in_first  input  1  beat starts a new accumulation group.
- in_last  input  1  beat ends the group.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DWACC  accumulated result.
- out_ovf  output  1  the group saturated or wrapped at least once.
- err_restart  output  1  one-cycle pulse: in_first arrived while a group was open.

Behaviour:
- Reset: all of the following are 0 — in_ready, out_valid, out_data, out_ovf, err_restart, s1_valid, acc, acc_open, grp_ovf. in_ready rises in the first cycle after rst deasserts.
- A beat transfers on in_valid & in_ready; an output transfers on out_valid & out_ready.
- Stage 1 (resolve):
  - Register res = in_sum + (in_cay << 1), DWIN+1 bits, unsigned, together with first/last.
  - s1 advances when stage 2 can take it.
- Stage 2 (accumulate), when s1 advances:
  - next = (first ? 0 : acc) + res.
  - Overflow means the DWACC+1-bit sum ≥ 2^DWACC.
  - On overflow, acc becomes 2^DWACC-1 if SAT_EN, else the low DWACC bits; grp_ovf is set.
  - first clears grp_ovf before the OR.
  - acc_open is set by a beat without last and cleared by a beat with last.
  - If first & acc_open: err_restart pulses and the partial sum is discarded. This is not fatal.
- Output register:
  - On an s1 beat with last, load out_data = next value and out_ovf = grp_ovf | this overflow, and set out_valid.
  - out_valid stays high with data stable until out_ready.
  - out_valid clears on transfer unless a new result loads in the same cycle, in which case the new result replaces it.
- Stall rules:
  - s2_ok = !(s1_last & out_valid & !out_ready).
  - s1 advances when s1_valid & s2_ok.
  - in_ready = !s1_valid | s2_ok. This is combinational from out_ready, and there is no combinational path from in_valid.
  - Non-last beats never stall on a full output register.
- Latency: a last beat accepted at cycle t gives out_valid at t+2 when unstalled. Throughput is one beat per cycle.
- Single-beat groups (first & last) are legal.
- A last beat without first after a closed group accumulates onto the held acc; the upstream sequencer must not do this.
- An async rst mid-group drops the partial sum and any pending output. No output is produced for that group.

Decomposition:
- Shared constants header npu_cube_defs:
  - DWIN and DWACC defaults.
  - Carry-weight shift constant CAY_SHIFT=1, shared with the ADD_LEVEL modules.
- Sub-module npu_cube_csa_cpa:
  - Parameterised combinational resolver: sum + (cay << CAY_SHIFT) with carry-out.
  - Reused later for the other ADD_LEVEL outputs.

Test Plan:
- Single-beat group: in_sum=0x0005, in_cay=0x0003, first=last=1, out_ready=1 -> out_data=11 two cycles after acceptance, out_ovf=0.
- Three-beat group: resolved values 100, 200, 300 back to back -> one output of 600; out_valid pulses exactly once.
- Saturation with SAT_EN=1: 64 beats of in_sum=0x7FFF, in_cay=0x3FFF (resolved 65533 each) -> out_data=0x1FFFFF, out_ovf=1. With SAT_EN=0 the same stimulus gives 4194112 mod 2^21 = 2096960 and out_ovf=1.
- Backpressure: out_ready=0 while two single-beat groups of values 7 and 9 are sent:
  - out_data holds 7 and in_ready drops once the second last beat reaches s1.
  - Raising out_ready yields 7 then 9 with no loss or duplication.
- Restart error: a first beat of 10 without last, then a first&last beat of 4 -> err_restart pulses one cycle and out_data=4.
- Reset mid-group: assert rst after two non-last beats, release, then send a first&last beat of 3 -> out_data=3; no stale output appears.
